// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg
// Shared definitions for the SDRAM user-port arbiter.
//   - Default widths for address, burst size and data words.
//   - Arbiter state encoding.
//   - slot_w(): width of a slot index for a given number of ports.
package sdram_arb_pkg;

    localparam int NUM_PORTS_DEF = 2;
    localparam int ADDR_W_DEF    = 24;
    localparam int SIZE_W_DEF    = 10;
    localparam int DATA_W_DEF    = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        W_REQ = 3'd1,
        W_RUN = 3'd2,
        R_REQ = 3'd3,
        R_RUN = 3'd4
    } arb_state_t;

    // Each port owns two slots (write, read).
    function automatic int slot_w(input int nports);
        return (2 * nports > 1) ? $clog2(2 * nports) : 1;
    endfunction

endpackage

// File: rtl/rr_slot_picker.sv
// rr_slot_picker
// Combinational round-robin picker: returns the first set bit of req at or
// after index ptr, wrapping around.
// Ports:
//   req  in   N        request vector
//   ptr  in   IDX_W    search start index (must be < N)
//   hit  out  1        at least one request is set
//   sel  out  IDX_W    selected index (ptr when no hit)
module rr_slot_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             hit,
    output logic [IDX_W-1:0] sel
);

    // rot[k] is the request at distance k from ptr, rot_idx[k] its absolute index.
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] rot_idx [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            logic [IDX_W:0] sum;
            assign sum         = {1'b0, ptr} + (IDX_W+1)'(gi);
            assign rot_idx[gi] = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N))
                                                         : sum[IDX_W-1:0];
            assign rot[gi]     = req[rot_idx[gi]];
        end
    endgenerate

    // Scan from the far end so the closest request to ptr is assigned last.
    always_comb begin
        hit = 1'b0;
        sel = ptr;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                hit = 1'b1;
                sel = rot_idx[k];
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Shares one SDRAM controller user interface between NUM_PORTS requesters.
// One transaction in flight, round-robin over slots
// {p0 write, p0 read, p1 write, p1 read, ...}.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   p_wreq/p_waddr/p_wsize/p_wdata  per-port write request side
//   p_wstart/p_wen/p_wdone        per-port write pulses (granted port only)
//   p_rreq/p_raddr/p_rsize        per-port read request side
//   p_rstart/p_rvalid/p_rdone     per-port read pulses (granted port only)
//   p_rdata                       read data broadcast to all ports
//   user_w*/user_r*               controller user interface
//   grant_slot                    currently latched slot
//   busy                          transaction in flight
//   err_latch                     sticky protocol / beat-count error
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int SIZE_W    = SIZE_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    localparam int NUM_SLOTS = 2 * NUM_PORTS,
    localparam int SLOT_W    = slot_w(NUM_PORTS),
    localparam int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic [NUM_PORTS-1:0]        p_wreq,
    input  logic [NUM_PORTS*ADDR_W-1:0] p_waddr,
    input  logic [NUM_PORTS*SIZE_W-1:0] p_wsize,
    input  logic [NUM_PORTS*DATA_W-1:0] p_wdata,
    output logic [NUM_PORTS-1:0]        p_wstart,
    output logic [NUM_PORTS-1:0]        p_wen,
    output logic [NUM_PORTS-1:0]        p_wdone,

    input  logic [NUM_PORTS-1:0]        p_rreq,
    input  logic [NUM_PORTS*ADDR_W-1:0] p_raddr,
    input  logic [NUM_PORTS*SIZE_W-1:0] p_rsize,
    output logic [NUM_PORTS-1:0]        p_rstart,
    output logic [NUM_PORTS-1:0]        p_rvalid,
    output logic [DATA_W-1:0]           p_rdata,
    output logic [NUM_PORTS-1:0]        p_rdone,

    output logic                        user_wreq,
    output logic [ADDR_W-1:0]           user_waddr,
    output logic [SIZE_W-1:0]           user_wsize,
    output logic [DATA_W-1:0]           user_wdata,
    input  logic                        user_wstart,
    input  logic                        user_wen,
    input  logic                        user_wdone,

    output logic                        user_rreq,
    output logic [ADDR_W-1:0]           user_raddr,
    output logic [SIZE_W-1:0]           user_rsize,
    input  logic                        user_rstart,
    input  logic                        user_rvalid,
    input  logic                        user_rdone,
    input  logic [DATA_W-1:0]           user_rdata,

    output logic [SLOT_W-1:0]           grant_slot,
    output logic                        busy,
    output logic                        err_latch
);

    arb_state_t        state_reg, state_next;
    logic [SLOT_W-1:0] ptr_reg, slot_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [SIZE_W-1:0] size_reg, beat_reg;
    logic              err_reg;

    // Unpacked per-port views of the flat request buses.
    logic [NUM_SLOTS-1:0] req_vec;
    logic [ADDR_W-1:0]    waddr_arr [NUM_PORTS];
    logic [ADDR_W-1:0]    raddr_arr [NUM_PORTS];
    logic [SIZE_W-1:0]    wsize_arr [NUM_PORTS];
    logic [SIZE_W-1:0]    rsize_arr [NUM_PORTS];
    logic [DATA_W-1:0]    wdata_arr [NUM_PORTS];

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
            assign req_vec[2*gi]     = p_wreq[gi];
            assign req_vec[2*gi + 1] = p_rreq[gi];
            assign waddr_arr[gi]     = p_waddr[gi*ADDR_W +: ADDR_W];
            assign raddr_arr[gi]     = p_raddr[gi*ADDR_W +: ADDR_W];
            assign wsize_arr[gi]     = p_wsize[gi*SIZE_W +: SIZE_W];
            assign rsize_arr[gi]     = p_rsize[gi*SIZE_W +: SIZE_W];
            assign wdata_arr[gi]     = p_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    logic              pick_hit;
    logic [SLOT_W-1:0] pick_sel;
    logic [PORT_W-1:0] pick_port, gnt_port;
    logic              pick_is_read;

    rr_slot_picker #(
        .N     (NUM_SLOTS),
        .IDX_W (SLOT_W)
    ) u_picker (
        .req (req_vec),
        .ptr (ptr_reg),
        .hit (pick_hit),
        .sel (pick_sel)
    );

    // Slot index = 2*port + is_read.
    assign pick_port    = PORT_W'(pick_sel >> 1);
    assign pick_is_read = pick_sel[0];
    assign gnt_port     = PORT_W'(slot_reg >> 1);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pick_hit)    state_next = pick_is_read ? R_REQ : W_REQ;
            W_REQ:   if (user_wstart) state_next = W_RUN;
            W_RUN:   if (user_wdone)  state_next = IDLE;
            R_REQ:   if (user_rstart) state_next = R_RUN;
            R_RUN:   if (user_rdone)  state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Controller strobes are only honoured in the state that expects them;
    // anything else is dropped here and flagged as stray below.
    logic wstart_fwd, wen_fwd, wdone_fwd;
    logic rstart_fwd, rvalid_fwd, rdone_fwd;
    logic stray;

    always_comb begin
        user_wreq  = (state_reg == W_REQ);
        user_rreq  = (state_reg == R_REQ);
        busy       = (state_reg != IDLE);
        wstart_fwd = (state_reg == W_REQ) && user_wstart;
        wen_fwd    = (state_reg == W_RUN) && user_wen;
        wdone_fwd  = (state_reg == W_RUN) && user_wdone;
        rstart_fwd = (state_reg == R_REQ) && user_rstart;
        rvalid_fwd = (state_reg == R_RUN) && user_rvalid;
        rdone_fwd  = (state_reg == R_RUN) && user_rdone;
        stray      = (user_wstart && (state_reg != W_REQ)) ||
                     (user_wdone  && (state_reg != W_RUN)) ||
                     (user_rstart && (state_reg != R_REQ)) ||
                     (user_rdone  && (state_reg != R_RUN));
    end

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_route
            logic is_gnt;
            assign is_gnt       = (gnt_port == PORT_W'(gi));
            assign p_wstart[gi] = is_gnt && wstart_fwd;
            assign p_wen[gi]    = is_gnt && wen_fwd;
            assign p_wdone[gi]  = is_gnt && wdone_fwd;
            assign p_rstart[gi] = is_gnt && rstart_fwd;
            assign p_rvalid[gi] = is_gnt && rvalid_fwd;
            assign p_rdone[gi]  = is_gnt && rdone_fwd;
        end
    endgenerate

    // Address/size registers are shared by both channels: only one
    // transaction is ever in flight.
    assign user_waddr = addr_reg;
    assign user_wsize = size_reg;
    assign user_raddr = addr_reg;
    assign user_rsize = size_reg;
    assign user_wdata = wdata_arr[gnt_port];
    assign p_rdata    = user_rdata;
    assign grant_slot = slot_reg;
    assign err_latch  = err_reg;

    // ---------------- beat counter and latches ----------------
    logic              beat_strobe, txn_done;
    logic [SIZE_W-1:0] beat_inc, beat_now;

    assign beat_strobe = wen_fwd || rvalid_fwd;
    assign txn_done    = wdone_fwd || rdone_fwd;
    assign beat_inc    = (beat_reg == '1) ? beat_reg : beat_reg + SIZE_W'(1);
    // Count as seen in the done cycle, so a beat coinciding with done counts.
    assign beat_now    = beat_strobe ? beat_inc : beat_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg  <= '0;
            slot_reg <= '0;
            addr_reg <= '0;
            size_reg <= '0;
            beat_reg <= '0;
            err_reg  <= 1'b0;
        end else begin
            if ((state_reg == IDLE) && pick_hit) begin
                slot_reg <= pick_sel;
                addr_reg <= pick_is_read ? raddr_arr[pick_port] : waddr_arr[pick_port];
                size_reg <= pick_is_read ? rsize_arr[pick_port] : wsize_arr[pick_port];
                beat_reg <= '0;
            end else if (beat_strobe) begin
                beat_reg <= beat_inc;
            end

            if (txn_done) begin
                ptr_reg <= (slot_reg == SLOT_W'(NUM_SLOTS - 1)) ? '0 : slot_reg + SLOT_W'(1);
            end

            if (stray || (txn_done && (beat_now != size_reg))) begin
                err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller user interface (write channel: wreq/wstart/wen/wdone; read channel: rreq/rstart/rvalid/rdone) between NUM_PORTS requesters, e.g. the ULPI capture writer and the host readback reader.
- Serializes all transactions, one outstanding at a time, with round-robin fairness.
- Latches the granted address and size, and routes per-beat strobes and data to and from the granted port.
- Checks the beat count of every transaction against its requested size.

Parameters:
- NUM_PORTS, 2, number of requester ports
- ADDR_W, 24, word address width
- SIZE_W, 10, burst length field width (number of 16-bit words)
- DATA_W, 16, data word width

Ports:
- clk  in  1  controller clock (clk_sdram domain)
- rst  in  1  reset; synchronous, active-high
- p_wreq  in  NUM_PORTS  per-port write request (level)
- p_waddr  in  NUM_PORTS*ADDR_W  per-port write address
- p_wsize  in  NUM_PORTS*SIZE_W  per-port write length
- p_wdata  in  NUM_PORTS*DATA_W  per-port write data
- p_wstart  out  NUM_PORTS  write accepted pulse, granted port only
- p_wen  out  NUM_PORTS  write data strobe, granted port only
- p_wdone  out  NUM_PORTS  write complete pulse
- p_rreq  in  NUM_PORTS  per-port read request (level)
- p_raddr  in  NUM_PORTS*ADDR_W  per-port read address
- p_rsize  in  NUM_PORTS*SIZE_W  per-port read length
- p_rstart  out  NUM_PORTS  read accepted pulse
- p_rvalid  out  NUM_PORTS  read data valid, granted port only
- p_rdata  out  DATA_W  read data, broadcast to all ports
- p_rdone  out  NUM_PORTS  read complete pulse
- user_wreq, user_waddr, user_wsize, user_wdata  out  1/ADDR_W/SIZE_W/DATA_W  to controller
- user_wstart, user_wen, user_wdone  in  1  from controller
- user_rreq, user_raddr, user_rsize  out  1/ADDR_W/SIZE_W  to controller
- user_rstart, user_rvalid, user_rdone  in  1  from controller
- user_rdata  in  DATA_W  from controller
- grant_slot  out  clog2(2*NUM_PORTS)  currently granted slot
- busy  out  1  transaction in flight
- err_latch  out  1  sticky beat-count mismatch flag

Behaviour:
- Slots are ordered {p0 write, p0 read, p1 write, p1 read, ...}. Slot s is requesting when its p_wreq/p_rreq bit is high.
- States:
  - IDLE: the picker selects the first requesting slot at or after pointer ptr, wrapping around. On a hit, the slot, address and size are registered next cycle, and the state moves to W_REQ or R_REQ. user_wreq/user_rreq is asserted from that cycle, so it appears 1 cycle after p_*req is first sampled in IDLE.
  - W_REQ / R_REQ: user_*req held high until user_*start. The start pulse is forwarded combinationally to the granted p_*start. user_*req drops the cycle after start. State moves to W_RUN / R_RUN.
  - W_RUN / R_RUN: per-beat routing below. On user_*done, the pulse is forwarded to p_*done, ptr <= slot+1 (mod 2*NUM_PORTS), and the state returns to IDLE.
- Per-beat routing:
  - user_wen goes combinationally to p_wen[granted].
  - user_wdata = p_wdata[granted port], same cycle.
  - user_rvalid goes to p_rvalid[granted].
  - p_rdata = user_rdata, unregistered.
- Minimum gap between back-to-back transactions: 1 IDLE cycle after done.
- user_waddr/user_wsize/user_raddr/user_rsize come from the latched registers and are stable for the whole transaction.
- Requests are not withdrawable once latched. A p_*req drop after grant does not abort; the transaction completes normally. Requesters hold p_*req until their p_*start.
- Beat counter:
  - Cleared at grant.
  - +1 per user_wen (write) or user_rvalid (read), saturating at 2^SIZE_W-1.
  - A done may coincide with the last beat; that beat is counted.
  - If the counter value including any beat in the done cycle differs from the latched size, err_latch <= 1. err_latch is cleared only by rst.
- A user_*start or user_*done arriving outside the matching state is ignored and sets err_latch.
- Unused strobes and pulses to non-granted ports are 0.
- busy = (state != IDLE).
- Reset values:
  - state IDLE, ptr 0, grant_slot 0.
  - All user_*req, p_* pulses, busy and err_latch are 0.
  - Latched addr/size are 0.
- rst mid-transaction returns to IDLE immediately. The controller shares rst, so no cleanup is needed.

Decomposition:
- Shared package sdram_arb_pkg: width constants (ADDR_W, SIZE_W, DATA_W defaults) and the state enum (IDLE, W_REQ, W_RUN, R_REQ, R_RUN).
- One sub-module: rr_slot_picker. It is combinational: inputs are the request vector and ptr; outputs are hit and the selected slot index. It is reusable by other arbiters.

Test Plan:
- Single write: p_wreq[0]=1, addr 0x001000, size 4; controller starts 2 cycles later and gives 4 wen, then done. Expect user_wreq high 1 cycle after request, p_wstart[0] coincident with start, 4 p_wen[0] pulses with user_wdata = p_wdata[0], p_wdone[0], err_latch 0.
- Contention: p_wreq[0], p_rreq[0] and p_wreq[1] all asserted and held. Expect grant order slot 0 -> 1 -> 2, then wrap to slot 0 on re-request, with 1 idle cycle between transactions.
- Read routing: port 1 read at 0x00ABCD, size 3, with user_rdata 0x1111/0x2222/0x3333. Expect p_rvalid[1] three times, p_rvalid[0] never, p_rdone[1].
- Size mismatch: write size 8 completed after 7 wen. Expect err_latch=1 and it stays set until rst.
- Request withdrawn after grant: p_wreq[1] dropped in W_REQ. Expect user_wreq held until start, transaction completes, p_wdone[1] pulses.
- Reset mid-burst: rst after 2 of 4 read beats. Expect the cycle after rst that busy=0, all req outputs are 0, ptr=0, and a new request is granted normally.
